// File: rtl/img_mem_pkg.sv
// Shared definitions for the image RAM arbiter, the pixel controller and the display reader.
package img_mem_pkg;

    localparam int IMG_ADDR_W = 16;
    localparam int IMG_DATA_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/img_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot of the first set request strictly after rr_last, cyclically.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_last,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    logic [N_REQ-1:0] above;
    logic [N_REQ-1:0] req_hi;
    logic [N_REQ-1:0] cand;

    always_comb begin
        above = '0;
        for (int i = 0; i < N_REQ; i++) begin
            above[i] = (IDX_W'(i) > rr_last);
        end
    end

    // Prefer requesters above rr_last; otherwise wrap to the lowest index.
    assign req_hi = req & above;
    assign cand   = (|req_hi) ? req_hi : req;
    assign pick   = cand & (~cand + N_REQ'(1));
    assign any    = |req;

endmodule

// File: rtl/img_mem_arbiter.sv
// Round-robin arbiter sharing the single-port image RAM; bounded bursts, one beat per cycle,
// read data returned one cycle after the beat.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no owner, gnt=0; first pending request is picked
//   ST_BUSY | gnt one-hot on owner; beats counted, handover checked
module img_mem_arbiter
    import img_mem_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = IMG_ADDR_W,
    parameter int DATA_W    = IMG_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]  rr_last_q, rr_last_d;
    logic [N_REQ-1:0]  rd_owner_q, rd_owner_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [N_REQ-1:0]  pick_req;
    logic [N_REQ-1:0]  pick;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_req;
    logic              accept;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic [CNT_W-1:0]  cnt_inc;
    logic              burst_done;

    // While busy the owner is masked out and rr_last equals the owner, so the same
    // picker yields the next requester after the owner with no bubble.
    assign pick_req = (state_q == ST_BUSY) ? (req & ~gnt_q) : req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (pick_req),
        .rr_last (rr_last_q),
        .pick    (pick),
        .any     (pick_any)
    );

    always_comb begin
        own_addr  = '0;
        own_wdata = '0;
        own_we    = 1'b0;
        pick_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                own_addr  = addr[i*ADDR_W +: ADDR_W];
                own_wdata = wdata[i*DATA_W +: DATA_W];
                own_we    = we[i];
            end
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // A beat in the reset cycle is suppressed so no stray write reaches the RAM.
    assign owner_req  = |(gnt_q & req);
    assign accept     = owner_req & rst;
    assign cnt_inc    = beat_cnt_q + CNT_W'(accept);
    assign burst_done = (cnt_inc == BURST_LIM);

    assign mem_we      = accept & own_we;
    assign mem_addr    = accept ? own_addr  : mem_addr_q;
    assign mem_wdata   = accept ? own_wdata : mem_wdata_q;
    assign mem_addr_d  = mem_addr;
    assign mem_wdata_d = mem_wdata;

    assign rd_pend_d  = accept & ~own_we;
    assign rd_owner_d = gnt_q;

    assign gnt    = gnt_q;
    assign rvalid = rd_owner_q & {N_REQ{rd_pend_q}};
    assign rdata  = mem_rdata;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        rr_last_d  = rr_last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_BUSY;
                    gnt_d      = pick;
                    beat_cnt_d = '0;
                    rr_last_d  = pick_idx;
                end
            end
            ST_BUSY: begin
                if (!owner_req || (burst_done && pick_any)) begin
                    beat_cnt_d = '0;
                    if (pick_any) begin
                        gnt_d     = pick;
                        rr_last_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (burst_done) begin
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            beat_cnt_q  <= '0;
            rr_last_q   <= LAST_RST;
            rd_owner_q  <= '0;
            rd_pend_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            beat_cnt_q  <= beat_cnt_d;
            rr_last_q   <= rr_last_d;
            rd_owner_q  <= rd_owner_d;
            rd_pend_q   <= rd_pend_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
